// File: rtl/gray_if.sv
// Sample/result bundle between an upstream Gray counter and gray_monitor.
// The master drives samples and err clears; the slave returns decoded results.
interface gray_if #(
  parameter int ERR_W = 8
);
  logic [3:0]       gray_in;
  logic             in_valid;
  logic             clr_err;
  logic [3:0]       bin_out;
  logic             out_valid;
  logic             step_err;
  logic             locked;
  logic [ERR_W-1:0] err_cnt;
  logic [7:0]       wrap_cnt;

  modport master (
    output gray_in, in_valid, clr_err,
    input  bin_out, out_valid, step_err, locked, err_cnt, wrap_cnt
  );

  modport slave (
    input  gray_in, in_valid, clr_err,
    output bin_out, out_valid, step_err, locked, err_cnt, wrap_cnt
  );
endinterface

// File: rtl/gray_monitor.sv
// Decodes a 4-bit Gray stream to binary, checks each step is a +1 increment,
// and tracks lock status, bad-step count and wrap count.
module gray_monitor #(
  parameter int LOCK_COUNT = 3,
  parameter int ERR_W      = 8
) (
  input logic   clk,
  input logic   rst,
  gray_if.slave bus
);

  localparam int RUN_W = $clog2(LOCK_COUNT + 1);

  typedef enum logic [1:0] {IDLE, TRACK, LOCKED} state_e;

  state_e           state_q,     state_d;
  logic [RUN_W-1:0] run_q,       run_d;
  logic [3:0]       prev_bin_q,  prev_bin_d;
  logic [3:0]       bin_out_q,   bin_out_d;
  logic             out_valid_q, out_valid_d;
  logic             step_err_q,  step_err_d;
  logic             locked_q,    locked_d;
  logic [ERR_W-1:0] err_cnt_q,   err_cnt_d;
  logic [7:0]       wrap_cnt_q,  wrap_cnt_d;

  logic [3:0]       bin_new;
  logic [3:0]       prev_inc;
  logic [RUN_W-1:0] run_inc;
  logic             good_step;

  function automatic logic [3:0] gray2bin(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    run_d       = run_q;
    prev_bin_d  = prev_bin_q;
    bin_out_d   = bin_out_q;
    out_valid_d = 1'b0;
    step_err_d  = 1'b0;
    wrap_cnt_d  = wrap_cnt_q;
    err_cnt_d   = err_cnt_q;

    bin_new   = gray2bin(bus.gray_in);
    prev_inc  = prev_bin_q + 4'd1;
    run_inc   = run_q + RUN_W'(1);
    good_step = (bin_new == prev_inc);

    if (bus.in_valid) begin
      bin_out_d   = bin_new;
      out_valid_d = 1'b1;
      prev_bin_d  = bin_new;
      unique case (state_q)
        IDLE: begin
          state_d = TRACK;
          run_d   = '0;
        end
        TRACK: begin
          if (good_step) begin
            run_d = run_inc;
            if (run_inc == RUN_W'(LOCK_COUNT)) state_d = LOCKED;
          end else begin
            run_d      = '0;
            step_err_d = 1'b1;
          end
        end
        LOCKED: begin
          if (!good_step) begin
            state_d    = TRACK;
            run_d      = '0;
            step_err_d = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          run_d   = '0;
        end
      endcase
      // A good step out of 15 necessarily lands on 0; the IDLE sample is never a step.
      if (state_q != IDLE && good_step && prev_bin_q == 4'hF)
        wrap_cnt_d = wrap_cnt_q + 8'd1;
    end

    locked_d = (state_d == LOCKED);

    if (bus.clr_err)
      err_cnt_d = step_err_d ? ERR_W'(1) : '0;
    else if (step_err_d && err_cnt_q != '1)
      err_cnt_d = err_cnt_q + ERR_W'(1);
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q     <= IDLE;
      run_q       <= '0;
      prev_bin_q  <= '0;
      bin_out_q   <= '0;
      out_valid_q <= 1'b0;
      step_err_q  <= 1'b0;
      locked_q    <= 1'b0;
      err_cnt_q   <= '0;
      wrap_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      prev_bin_q  <= prev_bin_d;
      bin_out_q   <= bin_out_d;
      out_valid_q <= out_valid_d;
      step_err_q  <= step_err_d;
      locked_q    <= locked_d;
      err_cnt_q   <= err_cnt_d;
      wrap_cnt_q  <= wrap_cnt_d;
    end
  end

  assign bus.bin_out   = bin_out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.step_err  = step_err_q;
  assign bus.locked    = locked_q;
  assign bus.err_cnt   = err_cnt_q;
  assign bus.wrap_cnt  = wrap_cnt_q;

endmodule
